// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder issue scheduler: the default datapath
// geometry and the tag carried alongside each operation in the adder pipe.
package adder_sched_pkg;

    localparam int WIDTH   = 32;
    localparam int LAT     = 4;
    // Widest requester ID a tag can carry (up to 16 requesters).
    localparam int TAG_IDW = 4;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request found
// when searching upward from the pointer, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int pos;

    // Walk the requesters starting at the pointer and latch onto the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!grant_any && req[pos]) begin
                grant_any  = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/adder_issue_arbiter.sv
// Shares one stallable pipelined adder between NREQ requesters. A tag pipe
// (valid + requester ID) runs in lockstep with the adder stages so every
// sum leaving the adder can be labelled with the requester that issued it.
// Consumer back-pressure freezes both the adder and the tag pipe.
module adder_issue_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDW   = 1,
    parameter int WIDTH = adder_sched_pkg::WIDTH,
    parameter int LAT   = adder_sched_pkg::LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    output logic                  add_stop,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout
);
    import adder_sched_pkg::*;

    tag_t            tags [LAT];
    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  rr_next;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic            stall;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            cin_q;

    // A finished result nobody takes freezes the whole pipe; no grants are
    // offered while stalled or while reset is held.
    assign stall   = tags[LAT-1].valid & ~res_ready;
    assign arb_req = (stall || !rst) ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (rr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign add_stop  = stall;
    assign res_valid = tags[LAT-1].valid;
    assign res_id    = IDW'(tags[LAT-1].id);
    assign res_sum   = add_sum;
    assign res_cout  = add_cout;

    // Pointer moves to the requester just after the winner, wrapping to 0.
    always_comb begin
        rr_next = grant_idx + IDW'(1);
        if (int'(grant_idx) == NREQ - 1) begin
            rr_next = '0;
        end
    end

    // Adder operands: hold while frozen, else the granted slice or a zero bubble.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (stall) begin
            add_a   = a_q;
            add_b   = b_q;
            add_cin = cin_q;
        end else if (grant_any) begin
            add_a   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
            add_b   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
            add_cin = req_cin[grant_idx];
        end
    end

    // Tag pipe, round-robin pointer and operand hold registers advance together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LAT; s++) begin
                tags[s] <= '0;
            end
            rr    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (!stall) begin
            tags[0].valid <= grant_any;
            tags[0].id    <= TAG_IDW'(grant_idx);
            for (int s = 1; s < LAT; s++) begin
                tags[s] <= tags[s-1];
            end
            if (grant_any) begin
                rr <= rr_next;
            end
            a_q   <= add_a;
            b_q   <= add_b;
            cin_q <= add_cin;
        end
    end

endmodule

// File: tb/tb_adder_issue_arbiter.sv
// Self-checking bench for adder_issue_arbiter. A behavioural stallable adder
// sits next to the DUT; a transaction-queue reference model predicts grants,
// stalls, operands and every result with its requester ID.
module tb_adder_issue_arbiter;

    localparam int NREQ  = 2;
    localparam int IDW   = 1;
    localparam int WIDTH = 32;
    localparam int LAT   = 4;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic                  add_stop;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;

    int assertCount;
    int failCount;

    // Reference model: outstanding operations in issue order with their age.
    int             idQ  [$];
    logic [WIDTH:0] valQ [$];
    int             ageQ [$];
    int             rrModel;
    logic [WIDTH-1:0] prevA;
    logic [WIDTH-1:0] prevB;
    logic             prevCin;

    logic [WIDTH:0] addPipe [LAT];

    adder_issue_arbiter #(
        .NREQ  (NREQ),
        .IDW   (IDW),
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_stop  (add_stop),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .res_cout  (res_cout)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external stallable adder; never reset, starts with junk.
    initial begin
        for (int k = 0; k < LAT; k++) begin
            addPipe[k] = {1'b0, $urandom};
        end
    end

    always @(posedge clk) begin
        if (!add_stop) begin
            addPipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
            for (int k = 1; k < LAT; k++) begin
                addPipe[k] <= addPipe[k-1];
            end
        end
    end

    assign add_sum  = addPipe[LAT-1][WIDTH-1:0];
    assign add_cout = addPipe[LAT-1][WIDTH];

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance it.
    task automatic applyStimulus(input logic [NREQ-1:0] valid,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic [NREQ-1:0] cin, input logic ready);
        logic             expValid;
        logic             expStall;
        logic [NREQ-1:0]  expGrant;
        int               expIdx;
        logic [WIDTH-1:0] expA;
        logic [WIDTH-1:0] expB;
        logic             expCin;
        @(negedge clk);
        req_valid = valid;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_cin   = cin;
        res_ready = ready;
        #1;
        expValid = (idQ.size() > 0) && (ageQ[0] == LAT - 1);
        expStall = expValid && !ready;
        expGrant = '0;
        expIdx   = -1;
        if (!expStall) begin
            for (int k = 0; k < NREQ; k++) begin
                int p;
                p = (rrModel + k) % NREQ;
                if (expIdx < 0 && valid[p]) expIdx = p;
            end
        end
        if (expIdx >= 0) expGrant[expIdx] = 1'b1;
        if (expStall) begin
            expA = prevA;
            expB = prevB;
            expCin = prevCin;
        end else if (expIdx == 0) begin
            expA = a0;
            expB = b0;
            expCin = cin[0];
        end else if (expIdx == 1) begin
            expA = a1;
            expB = b1;
            expCin = cin[1];
        end else begin
            expA = '0;
            expB = '0;
            expCin = 1'b0;
        end
        checkOutput("res_valid", 64'(res_valid), 64'(expValid));
        checkOutput("add_stop", 64'(add_stop), 64'(expStall));
        checkOutput("req_ready", 64'(req_ready), 64'(expGrant));
        checkOutput("add_a", 64'(add_a), 64'(expA));
        checkOutput("add_b", 64'(add_b), 64'(expB));
        checkOutput("add_cin", 64'(add_cin), 64'(expCin));
        if (expValid) begin
            checkOutput("res_id", 64'(res_id), 64'(idQ[0]));
            checkOutput("res_sum", 64'(res_sum), 64'(valQ[0][WIDTH-1:0]));
            checkOutput("res_cout", 64'(res_cout), 64'(valQ[0][WIDTH]));
        end
        if (expValid && ready) begin
            void'(idQ.pop_front());
            void'(valQ.pop_front());
            void'(ageQ.pop_front());
        end
        if (!expStall) begin
            for (int k = 0; k < ageQ.size(); k++) begin
                ageQ[k] = ageQ[k] + 1;
            end
            if (expIdx >= 0) begin
                idQ.push_back(expIdx);
                valQ.push_back({1'b0, expA} + {1'b0, expB} + {{WIDTH{1'b0}}, expCin});
                ageQ.push_back(0);
                rrModel = (expIdx + 1) % NREQ;
            end
            prevA   = expA;
            prevB   = expB;
            prevCin = expCin;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus('0, '0, '0, '0, '0, '0, 1'b1);
        end
    endtask

    // Pulse reset mid-cycle and confirm everything drops asynchronously.
    task automatic pulseReset();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_add_stop", 64'(add_stop), 64'd0);
        checkOutput("rst_add_a", 64'(add_a), 64'd0);
        checkOutput("rst_res_id", 64'(res_id), 64'd0);
        req_valid = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idQ.delete();
        valQ.delete();
        ageQ.delete();
        rrModel = 0;
        prevA   = '0;
        prevB   = '0;
        prevCin = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rrModel     = 0;
        prevA       = '0;
        prevB       = '0;
        prevCin     = 1'b0;
        rst         = 1'b0;
        req_valid   = 2'b11;
        req_a       = '1;
        req_b       = '1;
        req_cin     = '1;
        res_ready   = 1'b0;
        #3;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_res_id", 64'(res_id), 64'd0);
        checkOutput("reset_add_stop", 64'(add_stop), 64'd0);
        checkOutput("reset_add_a", 64'(add_a), 64'd0);
        checkOutput("reset_add_cin", 64'(add_cin), 64'd0);
        req_valid = '0;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] single request");
        applyStimulus(2'b01, 32'h1, 32'h1, '0, '0, 2'b00, 1'b1);
        idleCycles(LAT + 1);

        $display("[TB] contention");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 32'(i), 32'h1, 32'h100 + 32'(i), 32'h1, 2'b11, 1'b1);
        end
        idleCycles(LAT + 1);

        $display("[TB] back-pressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 32'h10 + 32'(i), 32'h5, 32'h20 + 32'(i), 32'h7, 2'b01, 1'b1);
        end
        applyStimulus('0, '0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 32'hAA, 32'hBB, 32'hCC, 32'hDD, 2'b11, 1'b0);
        end
        idleCycles(LAT + 2);

        $display("[TB] overflow");
        applyStimulus(2'b10, '0, '0, 32'hFFFF_FFFF, 32'h1, 2'b00, 1'b1);
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 2'b01, 1'b1);
        idleCycles(LAT + 1);

        $display("[TB] reset mid-flight");
        applyStimulus(2'b01, 32'h3, 32'h4, '0, '0, 2'b00, 1'b1);
        applyStimulus(2'b10, '0, '0, 32'h5, 32'h6, 2'b00, 1'b1);
        pulseReset();
        applyStimulus(2'b11, 32'h7, 32'h8, 32'h9, 32'hA, 2'b00, 1'b1);
        idleCycles(LAT + 2);

        $display("[TB] idle bubbles");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 32'h40 + 32'(i), 32'h2, 32'h80 + 32'(i), 32'h3, 2'b00, 1'b1);
            applyStimulus('0, '0, '0, '0, '0, '0, 1'b1);
        end
        idleCycles(LAT + 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] ra0, rb0, ra1, rb1;
            ra0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb0 = $urandom;
            ra1 = $urandom;
            rb1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            applyStimulus(2'($urandom_range(0, 3)), ra0, rb0, ra1, rb1,
                          2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end
        idleCycles(LAT + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
